// File: rtl/sp_param.sv
// sp_param: single-cycle MIPS-like core, one instruction retired per valid cycle.
// Register file r[] is exposed by name; data memory is external and combinational.
module sp_param #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 32,
    parameter int MEM_AW  = 12,
    parameter int R0_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       inst,
    output logic              out_valid,
    output logic [DATA_W-1:0] inst_addr,
    output logic              illegal,
    output logic              mem_wen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int RW = $clog2(NREG);

    logic [DATA_W-1:0] r [0:NREG-1];
    logic [DATA_W-1:0] r_pc;
    logic              r_out_valid;
    logic              r_illegal;

    logic [5:0]        w_op;
    logic [5:0]        w_func;
    logic [4:0]        w_shamt;
    logic [RW-1:0]     w_rs;
    logic [RW-1:0]     w_rt;
    logic [RW-1:0]     w_rd;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_zimm;
    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] w_jmp;
    logic [DATA_W-1:0] w_next_pc;
    logic [DATA_W-1:0] w_wr_data;
    logic [RW-1:0]     w_wr_idx;
    logic              w_wr_en;
    logic              w_ill;

    assign w_op    = inst[31:26];
    assign w_func  = inst[5:0];
    assign w_shamt = inst[10:6];
    assign w_rs    = inst[21 +: RW];
    assign w_rt    = inst[16 +: RW];
    assign w_rd    = inst[11 +: RW];
    assign w_a     = r[w_rs];
    assign w_b     = r[w_rt];
    assign w_simm  = DATA_W'($signed(inst[15:0]));
    assign w_zimm  = DATA_W'(inst[15:0]);
    assign w_lui   = DATA_W'($signed({inst[15:0], 16'h0000}));
    assign w_pc4   = r_pc + DATA_W'(4);
    assign w_jmp   = {w_pc4[DATA_W-1:28], inst[25:0], 2'b00};

    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;
    assign inst_addr = r_pc;
    assign mem_wen   = in_valid && (w_op == 6'd6);
    assign mem_addr  = MEM_AW'(w_a + w_simm);
    assign mem_wdata = w_b;

    always_comb begin
        w_next_pc = w_pc4;
        w_wr_en   = 1'b0;
        w_wr_idx  = w_rt;
        w_wr_data = '0;
        w_ill     = 1'b0;
        case (w_op)
            6'd0: begin
                w_wr_idx = w_rd;
                w_wr_en  = 1'b1;
                case (w_func)
                    6'd0: w_wr_data = w_a & w_b;
                    6'd1: w_wr_data = w_a | w_b;
                    6'd2: w_wr_data = w_a + w_b;
                    6'd3: w_wr_data = w_a - w_b;
                    6'd4: w_wr_data = DATA_W'($signed(w_a) < $signed(w_b));
                    6'd5: w_wr_data = w_a << w_shamt;
                    6'd6: w_wr_data = ~(w_a | w_b);
                    6'd7: begin
                        w_wr_en   = 1'b0;
                        w_next_pc = w_a;
                    end
                    6'd8: w_wr_data = w_a >> w_shamt;
                    6'd9: w_wr_data = $signed(w_a) >>> w_shamt;
                    default: begin
                        w_wr_en = 1'b0;
                        w_ill   = 1'b1;
                    end
                endcase
            end
            6'd1: begin w_wr_en = 1'b1; w_wr_data = w_a & w_zimm; end
            6'd2: begin w_wr_en = 1'b1; w_wr_data = w_a | w_zimm; end
            6'd3: begin w_wr_en = 1'b1; w_wr_data = w_a + w_simm; end
            6'd4: begin w_wr_en = 1'b1; w_wr_data = w_a - w_simm; end
            6'd5: begin w_wr_en = 1'b1; w_wr_data = mem_rdata; end
            6'd6: ;
            6'd7: w_next_pc = (w_a == w_b) ? w_pc4 + (w_simm << 2) : w_pc4;
            6'd8: w_next_pc = (w_a != w_b) ? w_pc4 + (w_simm << 2) : w_pc4;
            6'd9: begin w_wr_en = 1'b1; w_wr_data = w_lui; end
            6'd10: w_next_pc = w_jmp;
            6'd11: begin
                w_next_pc = w_jmp;
                w_wr_en   = 1'b1;
                w_wr_idx  = RW'(NREG - 1);
                w_wr_data = w_pc4;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Reset wins over an in-flight instruction: nothing commits at that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            for (int i = 0; i < NREG; i++) r[i] <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_illegal   <= in_valid && w_ill;
            if (in_valid) begin
                r_pc <= w_next_pc;
                if (w_wr_en && !(R0_ZERO != 0 && w_wr_idx == '0)) r[w_wr_idx] <= w_wr_data;
            end
        end
    end
endmodule

// File: tb/tb_sp_param.sv
// tb_sp_param: scoreboard bench for sp_param (default config plus NREG=16/R0_ZERO=1 instance).
module tb_sp_param;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] inst;
    logic        out_valid;
    logic [31:0] inst_addr;
    logic        illegal;
    logic        mem_wen;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        s_in_valid;
    logic [31:0] s_inst;
    logic        s_out_valid;
    logic [31:0] s_inst_addr;
    logic        s_illegal;
    logic        s_mem_wen;
    logic [11:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [31:0] s_mem_rdata;

    logic [31:0] mem [0:4095];

    typedef struct packed {
        logic [31:0] pc;
        logic        ill;
    } exp_t;
    exp_t q[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 0;

    sp_param dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst),
        .out_valid(out_valid), .inst_addr(inst_addr), .illegal(illegal),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    sp_param #(.NREG(16), .R0_ZERO(1)) d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .inst(s_inst),
        .out_valid(s_out_valid), .inst_addr(s_inst_addr), .illegal(s_illegal),
        .mem_wen(s_mem_wen), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(s_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign s_mem_rdata = '0;
    always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;

    // Retire monitor: every out_valid pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected pc=%h", inst_addr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (inst_addr !== e.pc || illegal !== e.ill) begin
                    errors++;
                    $display("FAIL retire got pc=%h ill=%b want pc=%h ill=%b", inst_addr, illegal, e.pc, e.ill);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rt_(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jt(input logic [5:0] op, input logic [25:0] a);
        return {op, a};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] nxt, input logic ill);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        inst     = ins;
        e.pc     = nxt;
        e.ill    = ill;
        q.push_back(e);
        exp_pc   = nxt;
    endtask

    task automatic step(input logic [31:0] ins, input logic ill);
        issue(ins, exp_pc + 32'd4, ill);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic any;
        rst_n = 1'b0; in_valid = 1'b0; inst = '0; s_in_valid = 1'b0; s_inst = '0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || inst_addr !== 32'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b pc=%h ill=%b want 0", out_valid, inst_addr, illegal);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            any = 1'b0;
            for (int i = 0; i < 32; i++) if (dut.r[i] !== 32'd0) any = 1'b1;
            checks++;
            if (out_valid !== 1'b0 || inst_addr !== 32'd0 || any) begin
                errors++;
                $display("FAIL idle_cycle%0d got ov=%b pc=%h regs_nonzero=%b want 0", c, out_valid, inst_addr, any);
            end
        end
        exp_pc = 0;
    endtask

    task automatic test_shift();
        step(it(6'd3, 5'd0, 5'd1, 16'hFFFF), 1'b0);
        step(rt_(6'd8, 5'd1, 5'd0, 5'd2, 5'd4), 1'b0);
        step(rt_(6'd9, 5'd1, 5'd0, 5'd3, 5'd4), 1'b0);
        idle();
        checks++;
        if (dut.r[1] !== 32'hFFFFFFFF || dut.r[2] !== 32'h0FFFFFFF || dut.r[3] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL shift got r1=%h r2=%h r3=%h want FFFFFFFF 0FFFFFFF FFFFFFFF", dut.r[1], dut.r[2], dut.r[3]);
        end
    endtask

    task automatic test_mem();
        step(it(6'd3, 5'd0, 5'd4, 16'h0FFF), 1'b0);
        step(it(6'd6, 5'd4, 5'd1, 16'h0002), 1'b0);
        #1;
        checks++;
        if (mem_wen !== 1'b1 || mem_addr !== 12'd1 || mem_wdata !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sw_strobe got wen=%b addr=%h data=%h want 1 001 FFFFFFFF", mem_wen, mem_addr, mem_wdata);
        end
        step(it(6'd5, 5'd4, 5'd5, 16'h0002), 1'b0);
        #1;
        checks++;
        if (mem_wen !== 1'b0 || mem_addr !== 12'd1) begin
            errors++;
            $display("FAIL lw_addr got wen=%b addr=%h want 0 001", mem_wen, mem_addr);
        end
        idle();
        checks++;
        if (dut.r[5] !== 32'hFFFFFFFF || mem[1] !== 32'hFFFFFFFF || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL lw_data got r5=%h mem1=%h wen=%b want FFFFFFFF FFFFFFFF 0", dut.r[5], mem[1], mem_wen);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #2;
        checks++;
        if (inst_addr !== 32'd0 || dut.r[1] !== 32'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pc=%h r1=%h ov=%b want 0", inst_addr, dut.r[1], out_valid);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 0;
        step(it(6'd3, 5'd0, 5'd6, 16'd5), 1'b0);
        step(it(6'd3, 5'd0, 5'd7, 16'd7), 1'b0);
        issue(it(6'd7, 5'd0, 5'd0, 16'hFFFF), 32'd8, 1'b0);
        issue(it(6'd8, 5'd6, 5'd7, 16'd1), 32'd16, 1'b0);
        issue(jt(6'd11, 26'h40), 32'h100, 1'b0);
        issue(rt_(6'd7, 5'd31, 5'd0, 5'd0, 5'd0), 32'd20, 1'b0);
        step(it(6'd7, 5'd6, 5'd7, 16'd5), 1'b0);
        idle();
        checks++;
        if (dut.r[31] !== 32'd20 || dut.r[6] !== 32'd5 || dut.r[7] !== 32'd7) begin
            errors++;
            $display("FAIL branch_regs got r31=%h r6=%h r7=%h want 14 5 7", dut.r[31], dut.r[6], dut.r[7]);
        end
    endtask

    task automatic test_illegal();
        step(it(6'd63, 5'd0, 5'd6, 16'h1234), 1'b1);
        #1;
        checks++;
        if (mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL illegal_op_wen got %b want 0", mem_wen);
        end
        step(rt_(6'd12, 5'd6, 5'd7, 5'd7, 5'd0), 1'b1);
        #1;
        checks++;
        if (mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL illegal_func_wen got %b want 0", mem_wen);
        end
        idle();
        checks++;
        if (dut.r[6] !== 32'd5 || dut.r[7] !== 32'd7 || inst_addr !== 32'd32) begin
            errors++;
            $display("FAIL illegal_state got r6=%h r7=%h pc=%h want 5 7 20", dut.r[6], dut.r[7], inst_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins_t [12];
        logic [31:0] val_t [12];
        ins_t = '{it(6'd2, 5'd0, 5'd8, 16'h8000), it(6'd9, 5'd0, 5'd9, 16'h8000),
                  it(6'd3, 5'd0, 5'd10, 16'hFFFD), rt_(6'd4, 5'd10, 5'd8, 5'd11, 5'd0),
                  rt_(6'd3, 5'd8, 5'd10, 5'd12, 5'd0), rt_(6'd6, 5'd0, 5'd0, 5'd13, 5'd0),
                  rt_(6'd2, 5'd9, 5'd9, 5'd14, 5'd0), rt_(6'd5, 5'd8, 5'd0, 5'd15, 5'd16),
                  it(6'd1, 5'd13, 5'd16, 16'h00F0), it(6'd4, 5'd8, 5'd17, 16'd1),
                  rt_(6'd0, 5'd10, 5'd8, 5'd18, 5'd0), rt_(6'd1, 5'd8, 5'd10, 5'd19, 5'd0)};
        val_t = '{32'h00008000, 32'h80000000, 32'hFFFFFFFD, 32'h00000001,
                  32'h00008003, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                  32'h000000F0, 32'h00007FFF, 32'h00008000, 32'hFFFFFFFD};
        for (int i = 0; i < 12; i++) step(ins_t[i], 1'b0);
        idle();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dut.r[8+i] !== val_t[i]) begin
                errors++;
                $display("FAIL alu_r%0d got %h want %h", 8 + i, dut.r[8+i], val_t[i]);
            end
        end
    endtask

    task automatic test_nreg16();
        @(negedge clk);
        s_in_valid = 1'b1;
        s_inst     = it(6'd3, 5'd0, 5'd17, 16'd9);
        @(negedge clk);
        s_inst     = it(6'd3, 5'd0, 5'd0, 16'd5);
        @(negedge clk);
        s_in_valid = 1'b0;
        checks++;
        if (d16.r[1] !== 32'd9 || d16.r[0] !== 32'd0 || s_inst_addr !== 32'd8 || s_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL nreg16 got r1=%h r0=%h pc=%h ov=%b want 9 0 8 1", d16.r[1], d16.r[0], s_inst_addr, s_out_valid);
        end
        @(negedge clk);
        s_in_valid = 1'b1;
        s_inst     = it(6'd3, 5'd0, 5'd2, 16'd7);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (d16.r[1] !== 32'd0 || s_inst_addr !== 32'd0 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear got r1=%h pc=%h ov=%b want 0", d16.r[1], s_inst_addr, s_out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (d16.r[2] !== 32'd0 || s_inst_addr !== 32'd0) begin
            errors++;
            $display("FAIL midreset_abort got r2=%h pc=%h want 0 0", d16.r[2], s_inst_addr);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        s_inst = it(6'd3, 5'd0, 5'd3, 16'd3);
        @(negedge clk);
        s_in_valid = 1'b0;
        checks++;
        if (s_inst_addr !== 32'd4 || d16.r[3] !== 32'd3 || d16.r[2] !== 32'd0) begin
            errors++;
            $display("FAIL restart got pc=%h r3=%h r2=%h want 4 3 0", s_inst_addr, d16.r[3], d16.r[2]);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_mem();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_nreg16();
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
